// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI4 slave endpoint backed by a local flop-array memory.
// One write burst and one read burst may be in flight at the same time; each
// channel pair has its own small state machine with registered outputs.
// Optional feature macro: AXI_RESPONDER_WRAP_EN enables WRAP bursts (len 1/3/7/15).
module axi_sram_responder #(
  parameter int AxiBusWidth = 128,
  parameter int MemDepth    = 256,
  parameter int IdWWidth    = 4,
  parameter int IdRWidth    = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [IdWWidth-1:0]      awid,
  input  logic [31:0]              awaddr,
  input  logic [7:0]               awlen,
  input  logic [2:0]               awsize,
  input  logic [1:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [AxiBusWidth-1:0]   wdata,
  input  logic [AxiBusWidth/8-1:0] wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [IdWWidth-1:0]      bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [IdRWidth-1:0]      arid,
  input  logic [31:0]              araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [IdRWidth-1:0]      rid,
  output logic [AxiBusWidth-1:0]   rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready
);

  localparam int          BeatBytes  = AxiBusWidth / 8;
  localparam int          AddrLsb    = $clog2(BeatBytes);
  localparam int          IdxW       = $clog2(MemDepth);
  localparam logic [31:0] MemBytes   = 32'(MemDepth * BeatBytes);
  localparam logic [31:0] BeatStep   = 32'(BeatBytes);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

`ifdef AXI_RESPONDER_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  // A request is legal only for full-width beats and a supported burst type.
  function automatic logic req_legal(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size == 3'(AddrLsb)) &&
           ((burst == 2'd0) || (burst == 2'd1) || (WrapEn && (burst == 2'd2) && wrap_len_ok));
  endfunction

  // Address bits allowed to change between beats: none for FIXED, all for INCR,
  // and the wrap-window bits for WRAP.
  function automatic logic [31:0] burst_mask(input logic [1:0] burst, input logic [7:0] len);
    case (burst)
      2'd0:    return '0;
      2'd2:    return (({24'd0, len} + 32'd1) << AddrLsb) - 32'd1;
      default: return '1;
    endcase
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [31:0] mask);
    return (addr & ~mask) | ((addr + BeatStep) & mask);
  endfunction

  function automatic logic in_range(input logic [31:0] addr);
    return addr < MemBytes;
  endfunction

  logic [AxiBusWidth-1:0] mem [MemDepth];

  w_state_t                w_state;
  logic [IdWWidth-1:0]     w_id;
  logic [31:0]             w_addr;
  logic [31:0]             w_mask;
  logic [7:0]              w_len;
  logic [7:0]              w_cnt;
  logic                    w_illegal;
  logic                    w_bad;
  logic                    w_hs;
  logic                    w_in_range;
  logic                    w_beat_err;
  logic                    mem_we;
  logic [IdxW-1:0]         w_idx;

  r_state_t                r_state;
  logic [31:0]             r_addr;
  logic [31:0]             r_mask;
  logic [7:0]              r_len;
  logic [7:0]              r_cnt;
  logic [7:0]              r_cnt_next;
  logic                    r_bad;
  logic [31:0]             r_load_addr;
  logic                    r_load_bad;
  logic [IdxW-1:0]         r_load_idx;
  logic [AxiBusWidth-1:0]  r_load_data;
  logic [1:0]              r_load_resp;

  assign w_hs       = wvalid && wready;
  assign w_idx      = w_addr[AddrLsb +: IdxW];
  assign w_in_range = in_range(w_addr);
  assign w_beat_err = !w_in_range || (wlast ? (w_cnt != w_len) : (w_cnt == w_len));
  assign mem_we     = w_hs && !w_illegal && w_in_range && !rst_i;
  assign r_cnt_next = r_cnt + 8'd1;

  // Byte-lane memory update; contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < BeatBytes; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Write channel FSM: accept AW, consume W beats until wlast, then hold B.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state   <= W_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= '0;
      w_id      <= '0;
      w_addr    <= '0;
      w_mask    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_illegal <= 1'b0;
      w_bad     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready   <= 1'b0;
            wready    <= 1'b1;
            w_id      <= awid;
            w_addr    <= awaddr;
            w_mask    <= burst_mask(awburst, awlen);
            w_len     <= awlen;
            w_cnt     <= '0;
            w_illegal <= !req_legal(awsize, awburst, awlen);
            w_bad     <= 1'b0;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr <= next_addr(w_addr, w_mask);
            w_cnt  <= w_cnt + 8'd1;
            w_bad  <= w_bad || w_beat_err;
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= (w_illegal || w_bad || w_beat_err) ? RespSlvErr : RespOkay;
              w_state <= W_RESP;
            end
          end
        end
        default: begin
          if (bvalid && bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Selects the beat to load into the R registers: beat 0 from AR, later beats
  // from the running address.
  always_comb begin
    r_load_addr = (r_state == R_IDLE) ? araddr : r_addr;
    r_load_bad  = (r_state == R_IDLE) ? !req_legal(arsize, arburst, arlen) : r_bad;
    r_load_idx  = r_load_addr[AddrLsb +: IdxW];
    r_load_data = '0;
    r_load_resp = RespSlvErr;
    if (!r_load_bad && in_range(r_load_addr)) begin
      r_load_data = mem[r_load_idx];
      r_load_resp = RespOkay;
    end
  end

  // Read channel FSM: accept AR, then present registered beats back to back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      r_addr  <= '0;
      r_mask  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_bad   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= arid;
            rdata   <= r_load_data;
            rresp   <= r_load_resp;
            rlast   <= (arlen == 8'd0);
            r_len   <= arlen;
            r_cnt   <= '0;
            r_bad   <= r_load_bad;
            r_mask  <= burst_mask(arburst, arlen);
            r_addr  <= next_addr(araddr, burst_mask(arburst, arlen));
            r_state <= R_DATA;
          end
        end
        default: begin
          if (rvalid && rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              rdata  <= r_load_data;
              rresp  <= r_load_resp;
              rlast  <= (r_cnt_next == r_len);
              r_cnt  <= r_cnt_next;
              r_addr <= next_addr(r_addr, r_mask);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: scoreboard bench for axi_sram_responder.
// Stimulus tasks push expected B/R responses from a byte-level memory model;
// a negedge monitor pops and compares whenever a response handshakes.
module tb_axi_sram_responder;

  logic         clk;
  logic         rst;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  axi_sram_responder dut (
    .clk_i(clk), .rst_i(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic [3:0] id; logic [127:0] data; logic [1:0] resp; logic last;} r_exp_t;

  b_exp_t       exp_b[$];
  r_exp_t       exp_r[$];
  logic [127:0] model_mem [256];
  int           n_checks = 0;
  int           n_pass = 0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hang guard so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void check_output(input string name, input logic [127:0] act,
                                       input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    $display("[TB] FAIL %s: actual missing required present", name);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit legal(input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size);
    bit wrap_supported;
`ifdef AXI_RESPONDER_WRAP_EN
    wrap_supported = 1'b1;
`else
    wrap_supported = 1'b0;
`endif
    return (size == 3'd4) && ((burst == 2'd0) || (burst == 2'd1) ||
           ((burst == 2'd2) && wrap_supported && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)));
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return a < 32'd4096;
  endfunction

  // Address of beat i, straight from the burst definitions.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [1:0] burst, input int i);
    logic [31:0] step, total, base;
    step = 32'(i) * 32'd16;
    case (burst)
      2'd1: return start + step;
      2'd2: begin
        total = (32'(len) + 32'd1) * 32'd16;
        base  = start - (start % total);
        return base + ((start - base + step) % total);
      end
      default: return start;
    endcase
  endfunction

  function automatic bit ready_of(input int sel);
    case (sel)
      0:       return awready;
      1:       return wready;
      default: return arready;
    endcase
  endfunction

  // Called just after a posedge with valid driven; returns on the handshake edge.
  task automatic wait_ready(input int sel, input string name, inout int cycles);
    int n = 0;
    @(negedge clk);
    while (!ready_of(sel) && n < 50) begin
      @(posedge clk); cycles++; n++;
      @(negedge clk);
    end
    if (!ready_of(sel)) fail_now({name, "_timeout"});
    @(posedge clk); cycles++;
  endtask

  // Issues one write burst and records its expected effect and B response.
  task automatic apply_write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                   input logic [1:0] burst, input logic [2:0] size, input int nbeats,
                                   input int strb_mode, input bit fixed_pat, input int b_delay,
                                   output int cycles);
    logic [127:0] dq[$];
    logic [15:0]  sq[$];
    logic [127:0] d;
    logic [15:0]  s;
    logic [31:0]  a;
    bit lg, bad;
    int n;
    lg  = legal(len, burst, size);
    bad = !lg || (nbeats != int'(len) + 1);
    for (int i = 0; i < nbeats; i++) begin
      d = fixed_pat ? {16{8'hA5}} : rand128();
      s = (strb_mode == 0) ? 16'hFFFF : (strb_mode == 1) ? ((i == 2) ? 16'h000F : 16'hFFFF) : 16'($urandom);
      dq.push_back(d); sq.push_back(s);
      a = beat_addr(addr, len, burst, i);
      if (!in_range(a)) bad = 1'b1;
      else if (lg) begin
        for (int b = 0; b < 16; b++) if (s[b]) model_mem[a[11:4]][8*b +: 8] = d[8*b +: 8];
      end
    end
    exp_b.push_back('{id: id, resp: (bad ? 2'b10 : 2'b00)});
    cycles = 0;
    @(posedge clk); #1;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size;
    wait_ready(0, "aw", cycles);
    #1 awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = dq[i]; wstrb = sq[i]; wlast = (i == nbeats - 1);
      wait_ready(1, "w", cycles);
      #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = (b_delay == 0);
    @(negedge clk);
    check_output("b_valid_timing", {wready, bvalid}, 2'b01);
    if (b_delay > 0) begin
      repeat (b_delay) @(posedge clk);
      cycles += b_delay;
      #1 bready = 1'b1;
      @(negedge clk);
    end
    n = 0;
    while (!bvalid && n < 50) begin
      @(posedge clk); cycles++; n++;
      @(negedge clk);
    end
    if (!bvalid) fail_now("b_timeout");
    @(posedge clk); cycles++;
    #1 bready = 1'b0;
    @(negedge clk);
    check_output("b_release", {bvalid, awready}, 2'b01);
  endtask

  // Issues one read burst; rready_mode 0 = always, 1 = toggle, 2 = random.
  task automatic apply_read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                  input logic [1:0] burst, input logic [2:0] size, input int rready_mode,
                                  output int cycles);
    logic [31:0] a;
    bit lg, done;
    int n;
    lg = legal(len, burst, size);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, len, burst, i);
      if (!lg || !in_range(a)) exp_r.push_back('{id: id, data: '0, resp: 2'b10, last: (i == int'(len))});
      else exp_r.push_back('{id: id, data: model_mem[a[11:4]], resp: 2'b00, last: (i == int'(len))});
    end
    cycles = 0;
    @(posedge clk); #1;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size;
    wait_ready(2, "ar", cycles);
    #1 arvalid = 1'b0;
    done = 1'b0; n = 0;
    while (!done && n < 200) begin
      rready = (rready_mode == 0) ? 1'b1 : (rready_mode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      done = rvalid && rready && rlast;
      @(posedge clk); cycles++; n++;
      #1;
    end
    rready = 1'b0;
    if (!done) fail_now("r_timeout");
    @(negedge clk);
    check_output("r_release", {rvalid, arready}, 2'b01);
  endtask

  // Response monitor: compares handshaken beats with the scoreboard and
  // checks that stalled responses hold steady.
  logic       r_stall, b_stall;
  logic [6:0] r_hold_ctrl;
  logic [127:0] r_hold_data;
  logic [5:0] b_hold;
  always @(negedge clk) begin
    if (rst) begin
      r_stall = 1'b0;
      b_stall = 1'b0;
    end else begin
      if (r_stall) begin
        check_output("r_stall_ctrl", {rvalid, rid, rresp, rlast}, {1'b1, r_hold_ctrl});
        check_output("r_stall_data", rdata, r_hold_data);
      end
      if (b_stall) check_output("b_stall_hold", {bvalid, bid, bresp}, {1'b1, b_hold});
      if (rvalid && rready) begin
        if (exp_r.size() == 0) fail_now("r_unexpected_beat");
        else begin
          r_exp_t e;
          e = exp_r.pop_front();
          check_output("r_beat_ctrl", {rid, rresp, rlast}, {e.id, e.resp, e.last});
          check_output("r_beat_data", rdata, e.data);
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) fail_now("b_unexpected");
        else begin
          b_exp_t e;
          e = exp_b.pop_front();
          check_output("b_resp", {bid, bresp}, {e.id, e.resp});
        end
      end
      r_stall     = rvalid && !rready;
      r_hold_ctrl = {rid, rresp, rlast};
      r_hold_data = rdata;
      b_stall     = bvalid && !bready;
      b_hold      = {bid, bresp};
    end
  end

  // Main stimulus sequence.
  initial begin
    int wc, rc, nb;
    logic [3:0] id;
    logic [31:0] addr;
    logic [7:0] len;
    logic [1:0] burst;
    logic [2:0] size;
    logic [7:0] wrap_lens [4];
    wrap_lens = '{8'd1, 8'd3, 8'd7, 8'd15};
    $display("[TB] starting axi_sram_responder bench");
    rst = 1'b1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_flags", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
    check_output("reset_ids", {bid, bresp, rid, rresp}, 12'b0);
    check_output("reset_rdata", rdata, 128'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_output("after_reset_ready", {awready, arready}, 2'b11);

    // Fill the whole memory so every later read has known data.
    for (int k = 0; k < 16; k++)
      apply_write_burst(4'($urandom_range(0, 15)), 32'(k * 256), 8'd15, 2'd1, 3'd4, 16, 2, 1'b0, 0, wc);

    // Single beat with a fixed pattern, then read it back.
    apply_write_burst(4'd9, 32'h40, 8'd0, 2'd1, 3'd4, 1, 0, 1'b1, 0, wc);
    check_output("single_write_cycles", 32'(wc), 32'd3);
    apply_read_burst(4'd3, 32'h40, 8'd0, 2'd1, 3'd4, 0, rc);
    check_output("single_read_cycles", 32'(rc), 32'd2);

    // Partial strobe on beat 2, back-to-back readback.
    apply_write_burst(4'd5, 32'h100, 8'd3, 2'd1, 3'd4, 4, 1, 1'b0, 0, wc);
    apply_read_burst(4'd6, 32'h100, 8'd3, 2'd1, 3'd4, 0, rc);
    check_output("incr_read_cycles", 32'(rc), 32'd5);

    // Backpressure on R and B.
    apply_read_burst(4'd7, 32'h500, 8'd7, 2'd1, 3'd4, 1, rc);
    apply_write_burst(4'd8, 32'h600, 8'd1, 2'd1, 3'd4, 2, 2, 1'b0, 5, wc);
    apply_read_burst(4'd2, 32'h600, 8'd1, 2'd1, 3'd4, 2, rc);

    // Error cases.
    apply_write_burst(4'd1, 32'd4096, 8'd0, 2'd1, 3'd4, 1, 0, 1'b0, 0, wc);
    apply_read_burst(4'd1, 32'h0, 8'd0, 2'd1, 3'd4, 0, rc);
    apply_write_burst(4'd4, 32'h200, 8'd3, 2'd1, 3'd4, 2, 0, 1'b0, 0, wc);
    apply_write_burst(4'd4, 32'h240, 8'd1, 2'd1, 3'd4, 4, 0, 1'b0, 0, wc);
    apply_read_burst(4'd4, 32'h200, 8'd3, 2'd1, 3'd2, 0, rc);
    apply_read_burst(4'd4, 32'h240, 8'd3, 2'd1, 3'd4, 0, rc);
    apply_read_burst(4'd5, 32'hFE0, 8'd3, 2'd1, 3'd4, 0, rc);

    // Concurrent write and read to disjoint words.
    fork
      apply_write_burst(4'd10, 32'h400, 8'd3, 2'd1, 3'd4, 4, 2, 1'b0, 0, wc);
      apply_read_burst(4'd11, 32'h800, 8'd3, 2'd1, 3'd4, 0, rc);
    join
    check_output("concurrent_write_cycles", 32'(wc), 32'd6);
    check_output("concurrent_read_cycles", 32'(rc), 32'd5);

    // WRAP burst starting mid-window, read back both ways.
    apply_write_burst(4'd12, 32'h130, 8'd3, 2'd2, 3'd4, 4, 0, 1'b0, 0, wc);
    apply_read_burst(4'd13, 32'h130, 8'd3, 2'd2, 3'd4, 0, rc);
    apply_read_burst(4'd14, 32'h100, 8'd3, 2'd1, 3'd4, 0, rc);

    // Randomized traffic, including illegal and out-of-range bursts.
    for (int it = 0; it < 24; it++) begin
      id    = 4'($urandom_range(0, 15));
      addr  = 32'($urandom_range(0, 260)) * 32'd16;
      burst = 2'($urandom_range(0, 3));
      len   = (burst == 2'd2) ? wrap_lens[$urandom_range(0, 3)] : 8'($urandom_range(0, 7));
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      nb    = int'(len) + 1;
      if ($urandom_range(0, 9) == 0) nb = (len > 0) ? int'(len) : 2;
      apply_write_burst(id, addr, len, burst, size, nb, 2, 1'b0, $urandom_range(0, 3), wc);
      apply_read_burst(id, addr, len, burst, 3'd4, $urandom_range(0, 2), rc);
    end

    // Reset in the middle of a read burst.
    for (int i = 0; i < 8; i++)
      exp_r.push_back('{id: 4'd15, data: model_mem[8'h30 + 8'(i)], resp: 2'b00, last: (i == 7)});
    @(posedge clk); #1;
    arvalid = 1'b1; arid = 4'd15; araddr = 32'h300; arlen = 8'd7; arburst = 2'd1; arsize = 3'd4;
    wait_ready(2, "ar_rst", rc);
    #1 arvalid = 1'b0; rready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_output("rst_mid_read", {rvalid, rlast, arready, awready}, 4'b0);
    exp_r.delete();
    rready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_output("rst_release_ready", {rvalid, arready, awready}, 3'b011);
    apply_read_burst(4'd1, 32'h300, 8'd1, 2'd1, 3'd4, 0, rc);

    check_output("b_queue_drained", 32'(exp_b.size()), 32'd0);
    check_output("r_queue_drained", 32'(exp_r.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_sram_responder.md
# axi_sram_responder

AXI4 slave-side responder with a local flop-array memory, terminating the AW/W/B and AR/R channels that an `axi_transactor` master port or the interconnect drives. It accepts one write burst and, independently, one read burst at a time, stores/returns full-width beats, and generates B and R responses in a single clock domain. It is the endpoint for interconnect and CDC bench traffic, and a small on-chip scratch memory.

## Interface
- `AxiBusWidth`, 128, data width in bits; byte lanes = AxiBusWidth/8.
- `MemDepth`, 256, memory words of AxiBusWidth bits; power of two.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `axi_s_aw` in/out `axi_aw_if.slave`: write address; awid `ID_W_WIDTH`, awaddr 32, awlen 8, awsize 3, awburst 2.
- `axi_s_w` in/out `axi_w_if.slave`: write data, wstrb, wlast.
- `axi_s_b` in/out `axi_b_if.slave`: bid, bresp `BRESP_WIDTH`, bvalid/bready.
- `axi_s_ar` in/out `axi_ar_if.slave`: read address, same fields as AW, arid `ID_R_WIDTH`.
- `axi_s_r` in/out `axi_r_if.slave`: rid, rdata, rresp, rlast, rvalid/rready.
- ID/resp widths come from `axi_config.svh`.

## Operation
- Word index = addr[AddrLsb +: log2(MemDepth)], AddrLsb = log2(AxiBusWidth/8). In range iff addr < MemDepth*AxiBusWidth/8.
- Legal: awsize/arsize == AddrLsb; burst FIXED (0) or INCR (1); WRAP (2) per Configuration; burst 3 illegal.
- Beat address: FIXED constant; INCR +bytes per beat; 32-bit wrap ignored (no 4 KB check).
- Write FSM: W_IDLE (awready=1) -> AW handshake latches id/addr/len/burst/err -> W_DATA (wready=1). Each W handshake writes bytes with wstrb set, unless error or out of range (dropped), and advances the address. W handshake with wlast -> W_RESP (bvalid=1, bid=latched id). B handshake -> W_IDLE.
- bresp = OKAY (0) normally; SLVERR (2) if illegal size/burst, any beat out of range, or beat count != awlen+1. The burst always ends on wlast; extra/missing beats are not padded.
- Read FSM: R_IDLE (arready=1) -> AR handshake -> R_DATA. rvalid=1, rid=latched id, rlast=1 on beat index arlen. R handshake advances; handshake with rlast -> R_IDLE.
- rresp = SLVERR and rdata=0 for an illegal request (all beats) or an out-of-range beat; otherwise OKAY with memory data.
- Read and write FSMs run concurrently. A read beat is captured when loaded. A same-cycle write to that word is not visible in that beat (old data).
- Memory contents are not reset. Initial contents are X; the bench preloads by writing.

## Timing
- While rst_i=1: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0. Both FSMs go to IDLE.
- First cycle after rst_i falls: awready=1, arready=1.
- AW handshake at cycle N -> awready=0 and wready=1 from N+1.
- Write beats: 1/cycle while wvalid held.
- Last W handshake at M -> wready=0 and bvalid=1 at M+1.
- bvalid, bid, bresp are stable until bready. B handshake at K -> bvalid=0, awready=1 at K+1.
- AR handshake at N -> beat 0 valid at N+1 (rdata registered).
- Each R handshake presents the next beat the following cycle (back-to-back, no bubble). Outputs stay stable while rvalid=1 and rready=0.
- rlast handshake at K -> rvalid=0, arready=1 at K+1.
- Reset mid-burst aborts both FSMs: no B/R is issued for the aborted burst, and already-written words remain.

## Configuration
- `AXI_RESPONDER_WRAP_EN` defined: WRAP supported for len in {1,3,7,15}. Wrap boundary = (len+1)*bytes, aligned down from the start address; the address wraps to the boundary base. Other lens give SLVERR.
- Undefined: any WRAP request is illegal. Writes are dropped with bresp SLVERR; reads return SLVERR with rdata=0 for all beats. The handshake sequence is unchanged.

## Test plan
- Single write, awaddr=0x40, len=0, INCR, wdata=0xA5..., wstrb all 1 -> bvalid at M+1, bresp=0, bid=awid. Read of 0x40 returns the same data, rresp=0, rlast=1.
- INCR write len=3 at 0x100 with wstrb=0x000F on beat 2 -> INCR read len=3: only the low 4 bytes of word 0x120 are updated. Beats come back-to-back with rready=1, and rlast is high only on beat 3.
- Backpressure: rready toggled 1/0 during a len=7 read, bready held 0 for 5 cycles -> outputs stable while stalled, no beat lost or duplicated.
- Errors: awaddr=MemDepth*bytes -> bresp=2 and memory unchanged. wlast on beat 1 of len=3 -> bresp=2. Read with arsize=2 -> every beat has rresp=2 and rdata=0.
- Concurrent: a len=3 write and a len=3 read to disjoint addresses issued in the same cycle -> both complete with no stalls introduced by the other.
- WRAP len=3 at 0x130: with the macro, beats hit 0x130, 0x100, 0x110, 0x120 with OKAY; without it, SLVERR. Reset asserted mid-read -> rvalid=0 the next cycle and arready=1 after release.
